// File: rtl/sdp_pipe_param.sv
// sdp_pipe_param: three-stage add/subtract pipeline, n = (a +/- b) +/- c.
// P1 registers the operands, P2 holds m = a +/- b, P3 holds n = m +/- c.
// All stages advance together under a single enable with valid/ready
// handshaking on both ends. Each stage can wrap or saturate (unsigned).
// The result carries an overflow flag. A wrapping counter tracks results
// handed to the consumer.
module sdp_pipe_param #(
   parameter int WIDTH = 8,   // datapath width, 2..32
   parameter int SAT   = 0,   // 0 = wrap, 1 = unsigned saturate
   parameter int CNT_W = 16   // width of done_cnt
) (
   input  logic             clk,
   input  logic             reset,      // synchronous, active-low
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             ctl_1,      // stage 2: 1 = a+b, 0 = a-b
   input  logic             ctl_2,      // stage 3: 1 = m+c, 0 = m-c
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_ovf,
   output logic [CNT_W-1:0] done_cnt
);

   // One add/subtract step. The result is {ovf, value}.
   // The operation is done at WIDTH+1 bits, so bit WIDTH of the raw sum is
   // the carry for an add. For a subtract, bit WIDTH is the borrow (a < b).
   function automatic logic [WIDTH:0] arith(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic             add);
      logic [WIDTH:0]   wide;
      logic [WIDTH-1:0] res;
      wide = add ? ({1'b0, x} + {1'b0, y}) : ({1'b0, x} - {1'b0, y});
      res  = wide[WIDTH-1:0];
      if (SAT != 0 && wide[WIDTH])
         res = add ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
      return {wide[WIDTH], res};
   endfunction

   // Stage registers and their next-state values.
   logic             p1_valid_q, p1_valid_d;
   logic             p1_ctl1_q,  p1_ctl1_d;
   logic             p1_ctl2_q,  p1_ctl2_d;
   logic [WIDTH-1:0] p1_a_q,     p1_a_d;
   logic [WIDTH-1:0] p1_b_q,     p1_b_d;
   logic [WIDTH-1:0] p1_c_q,     p1_c_d;

   logic             p2_valid_q, p2_valid_d;
   logic             p2_ctl2_q,  p2_ctl2_d;
   logic [WIDTH-1:0] p2_m_q,     p2_m_d;
   logic [WIDTH-1:0] p2_c_q,     p2_c_d;
   logic             p2_ovf_q,   p2_ovf_d;

   logic             p3_valid_q, p3_valid_d;
   logic [WIDTH-1:0] p3_n_q,     p3_n_d;
   logic             p3_ovf_q,   p3_ovf_d;

   logic [CNT_W-1:0] cnt_q,      cnt_d;

   logic             en;
   logic [WIDTH:0]   s2_res;
   logic [WIDTH:0]   s3_res;

   // The pipeline moves only when the output slot is empty or is being
   // drained this cycle. Upstream ready is that same enable.
   assign en       = !p3_valid_q || out_ready;
   assign in_ready = en;

   // Stage arithmetic and next-state selection. When en is low, every
   // stage keeps its current contents.
   always_comb begin
      // NOTE: default every combinational output first, so that no path
      // leaves a signal unassigned and infers a latch.
      s2_res     = arith(p1_a_q, p1_b_q, p1_ctl1_q);
      s3_res     = arith(p2_m_q, p2_c_q, p2_ctl2_q);

      p1_valid_d = p1_valid_q;
      p1_ctl1_d  = p1_ctl1_q;
      p1_ctl2_d  = p1_ctl2_q;
      p1_a_d     = p1_a_q;
      p1_b_d     = p1_b_q;
      p1_c_d     = p1_c_q;
      p2_valid_d = p2_valid_q;
      p2_ctl2_d  = p2_ctl2_q;
      p2_m_d     = p2_m_q;
      p2_c_d     = p2_c_q;
      p2_ovf_d   = p2_ovf_q;
      p3_valid_d = p3_valid_q;
      p3_n_d     = p3_n_q;
      p3_ovf_d   = p3_ovf_q;
      cnt_d      = cnt_q;

      if (en) begin
         // Bubbles are not collapsed: the valid bits travel with the data.
         p1_valid_d = in_valid && in_ready;
         p1_ctl1_d  = ctl_1;
         p1_ctl2_d  = ctl_2;
         p1_a_d     = a;
         p1_b_d     = b;
         p1_c_d     = c;

         p2_valid_d = p1_valid_q;
         p2_ctl2_d  = p1_ctl2_q;
         p2_m_d     = s2_res[WIDTH-1:0];
         p2_c_d     = p1_c_q;
         p2_ovf_d   = s2_res[WIDTH];

         p3_valid_d = p2_valid_q;
         p3_n_d     = s3_res[WIDTH-1:0];
         p3_ovf_d   = p2_ovf_q | s3_res[WIDTH];
      end

      if (p3_valid_q && out_ready)
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // State register. Reset takes priority and drops any beats in flight.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the values from before the clock edge.
      if (!reset) begin
         p1_valid_q <= 1'b0;
         p1_ctl1_q  <= 1'b0;
         p1_ctl2_q  <= 1'b0;
         p1_a_q     <= '0;
         p1_b_q     <= '0;
         p1_c_q     <= '0;
         p2_valid_q <= 1'b0;
         p2_ctl2_q  <= 1'b0;
         p2_m_q     <= '0;
         p2_c_q     <= '0;
         p2_ovf_q   <= 1'b0;
         p3_valid_q <= 1'b0;
         p3_n_q     <= '0;
         p3_ovf_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         p1_valid_q <= p1_valid_d;
         p1_ctl1_q  <= p1_ctl1_d;
         p1_ctl2_q  <= p1_ctl2_d;
         p1_a_q     <= p1_a_d;
         p1_b_q     <= p1_b_d;
         p1_c_q     <= p1_c_d;
         p2_valid_q <= p2_valid_d;
         p2_ctl2_q  <= p2_ctl2_d;
         p2_m_q     <= p2_m_d;
         p2_c_q     <= p2_c_d;
         p2_ovf_q   <= p2_ovf_d;
         p3_valid_q <= p3_valid_d;
         p3_n_q     <= p3_n_d;
         p3_ovf_q   <= p3_ovf_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid = p3_valid_q;
   assign out       = p3_n_q;
   assign out_ovf   = p3_ovf_q;
   assign done_cnt  = cnt_q;

endmodule

// File: doc/sdp_pipe_param.md
Name: sdp_pipe_param

Overview:
Parametrised successor to the team's fixed 8-bit three-stage add/subtract pipeline.
- Same datapath shape: P1 registers the operands, P2 computes m = a±b, P3 computes n = m±c.
- Generalised to WIDTH bits, adds per-stage valid tracking with valid/ready backpressure, optional saturating arithmetic, a per-result overflow flag and a completed-result counter.
- Sits between an operand source and a consumer that may stall.

Parameters:
- WIDTH, 8, datapath width of a, b, c and out (legal range 2..32).
- SAT, 0, 0 = modular (wrap) arithmetic; 1 = unsigned saturating arithmetic.
- CNT_W, 16, width of done_cnt.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets all state.
- in_valid  input  1  operand beat present.
- in_ready  output  1  pipeline can accept a beat this cycle.
- ctl_1  input  1  stage-2 op: 1 = a+b, 0 = a-b.
- ctl_2  input  1  stage-3 op: 1 = m+c, 0 = m-c.
- a  input  WIDTH  operand a (unsigned).
- b  input  WIDTH  operand b (unsigned).
- c  input  WIDTH  operand c (unsigned).
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result n.
- out_ovf  output  1  result had a carry-out or borrow in stage 2 or stage 3.
- done_cnt  output  CNT_W  count of results handed off (out_valid && out_ready).

Behaviour:
- Reset (reset==0 at a rising edge): all stage valids, data, ctl and ovf registers go to 0. Outputs after reset: out_valid=0, out=0, out_ovf=0, done_cnt=0, in_ready=1. Reset overrides every other event in the same cycle; in-flight beats are discarded, not emitted.
- Advance enable: en = !p3_valid || out_ready, and in_ready = en. When en=1, all three stages shift together:
  - P1 <= {in_valid && in_ready, ctl_1, ctl_2, a, b, c}
  - P2 <= stage-2 result of P1
  - P3 <= stage-3 result of P2
- When en=0, every stage holds; out, out_valid and out_ovf stay stable.
- Bubbles are not collapsed: the valid bits travel with the data.
- Latency: a beat accepted in cycle t appears with out_valid=1 in cycle t+3 if not stalled. Each stall cycle adds exactly 1. Throughput is 1 beat/cycle while out_ready=1.
- Stage 2 arithmetic, computed at WIDTH+1 bits:
  - add: carry set when a+b > 2^WIDTH-1.
  - subtract: borrow set when a < b.
  - SAT=0: m = low WIDTH bits.
  - SAT=1: add overflow clamps m to 2^WIDTH-1; subtract underflow clamps m to 0.
  - ovf2 = carry|borrow, registered with m.
- Stage 3: same rules applied to m±c, giving n and ovf3. out_ovf = ovf2|ovf3, registered with n in P3.
- Bubble stages: data registers still load when en=1 (value irrelevant). out must only be checked when out_valid=1.
- done_cnt: increments by 1 on each cycle with out_valid && out_ready && reset==1. It wraps from 2^CNT_W-1 to 0.
- Simultaneous accept and emit in one cycle is legal and loses no beat.
- in_valid=1 with in_ready=0: the beat is not taken; the source must hold it.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 and out_ready=1 → out_valid=0, out=0, out_ovf=0, done_cnt=0, in_ready=1 throughout; first beat after release appears 3 cycles after acceptance.
- Wrap (WIDTH=8, SAT=0): a=200, b=100, ctl_1=1, c=50, ctl_2=0 → m=44, out=250, out_ovf=1 at t+3. Then a=10, b=3, ctl_1=0, c=5, ctl_2=1 → out=12, out_ovf=0.
- Saturate (WIDTH=8, SAT=1): a=200, b=100, ctl_1=1, c=50, ctl_2=0 → out=205, out_ovf=1. Then a=3, b=10, ctl_1=0, c=4, ctl_2=1 → m=0, out=4, out_ovf=1.
- Backpressure: stream values a=1..6 (b=0, c=0, ctl_1=1, ctl_2=1); drop out_ready for 2 cycles when out=1 first shows → out holds 1, in_ready=0 for those 2 cycles, outputs 1..6 in order with none lost or duplicated.
- Reset mid-operation: 3 beats in flight, reset=0 for one edge → out_valid=0 next cycle, none of the 3 beats emerge, done_cnt=0.
- Counter wrap (CNT_W=4): 17 handshakes → done_cnt runs 1..15, 0, then 1.
